// File: rtl/branch_predictor.sv
// Bimodal 2-bit saturating-counter branch predictor with a power-up INIT sweep of the table.
// Prediction latency 1 cycle, updates land at the end of their cycle; requests/updates are dropped until ready.
// Optional gshare indexing (global history XOR pc index) is enabled by defining BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor #(
    parameter int         INDEX_BITS = 6,
    parameter int         PC_LSB     = 2,
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int         GHR_BITS   = 6
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready,
    input  logic        pred_req,
    input  logic [63:0] pred_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [63:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_predicted,
    output logic [31:0] mispredict_count
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                state;
    logic [INDEX_BITS-1:0] ptr;
    logic [1:0]            tbl [ENTRIES];
    logic [INDEX_BITS-1:0] pidx;
    logic [INDEX_BITS-1:0] uidx;
    logic [1:0]            ucur;
    logic [1:0]            unext;
    logic [1:0]            pcur;
    logic                  run_upd;
    logic                  unused_pc;

    assign unused_pc = ^{pred_pc, upd_pc};
    assign run_upd   = (state == S_RUN) && upd_valid;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    localparam int GW = (GHR_BITS > INDEX_BITS) ? GHR_BITS : INDEX_BITS;

    logic [GHR_BITS-1:0] ghr;
    logic [GW-1:0]       ghr_ext;
    logic                unused_ghr;

    // History is zero-extended or truncated to the index width before hashing.
    assign ghr_ext    = GW'(ghr);
    assign unused_ghr = ^ghr_ext;
    assign pidx = pred_pc[PC_LSB +: INDEX_BITS] ^ ghr_ext[INDEX_BITS-1:0];
    assign uidx = upd_pc[PC_LSB +: INDEX_BITS]  ^ ghr_ext[INDEX_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
        end else if (run_upd) begin
            ghr <= GHR_BITS'({ghr, upd_taken});
        end
    end
`else
    assign pidx = pred_pc[PC_LSB +: INDEX_BITS];
    assign uidx = upd_pc[PC_LSB +: INDEX_BITS];
`endif

    always_comb begin
        ucur  = tbl[uidx];
        unext = ucur;
        if (upd_taken) begin
            if (ucur != 2'b11) unext = ucur + 2'b01;
        end else begin
            if (ucur != 2'b00) unext = ucur - 2'b01;
        end
        // Write-through: a same-cycle update to the same entry is visible to the prediction.
        pcur = tbl[pidx];
        if (run_upd && (uidx == pidx)) pcur = unext;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_INIT) begin
                tbl[ptr] <= INIT_STATE;
            end else if (upd_valid) begin
                tbl[uidx] <= unext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_INIT;
            ptr              <= '0;
            ready            <= 1'b0;
            pred_valid       <= 1'b0;
            pred_taken       <= 1'b0;
            mispredict_count <= '0;
        end else if (state == S_INIT) begin
            ptr        <= ptr + INDEX_BITS'(1);
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            if (&ptr) begin
                state <= S_RUN;
                ready <= 1'b1;
            end
        end else begin
            pred_valid <= pred_req;
            pred_taken <= pred_req & pcur[1];
            if (run_upd && (upd_taken != upd_predicted) && (mispredict_count != 32'hFFFF_FFFF)) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random traffic, checked every cycle against a reference model.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        pred_req;
    logic [63:0] pred_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic        upd_predicted;
    logic [31:0] mispredict_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_ctr [64];
    int          m_init_cycles;
    bit          m_ready;
    bit          m_pv;
    bit          m_pt;
    longint      m_count;
    int          m_ghr;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk              (clk),
        .reset            (reset),
        .ready            (ready),
        .pred_req         (pred_req),
        .pred_pc          (pred_pc),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_predicted    (upd_predicted),
        .mispredict_count (mispredict_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int index_of(input logic [63:0] pc);
        int ix;
        ix = int'((pc >> 2) % 64);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        ix = ix ^ (m_ghr % 64);
`endif
        return ix;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int pi, ui;
        if (reset) begin
            m_init_cycles = 0;
            m_ready = 0;
            m_pv = 0;
            m_pt = 0;
            m_count = 0;
            m_ghr = 0;
        end else if (!m_ready) begin
            m_init_cycles++;
            m_pv = 0;
            m_pt = 0;
            if (m_init_cycles == 64) begin
                m_ready = 1;
                for (int i = 0; i < 64; i++) m_ctr[i] = 1;
            end
        end else begin
            pi = index_of(pred_pc);
            ui = index_of(upd_pc);
            if (upd_valid) begin
                if (upd_taken && m_ctr[ui] < 3) m_ctr[ui]++;
                if (!upd_taken && m_ctr[ui] > 0) m_ctr[ui]--;
                if (upd_taken != upd_predicted && m_count < 64'hFFFF_FFFF) m_count++;
                m_ghr = ((m_ghr << 1) | int'(upd_taken)) % 64;
            end
            m_pv = pred_req;
            m_pt = pred_req && (m_ctr[pi] >= 2);
        end
    endtask

    task automatic cyc(input logic rst, input logic rq, input logic [63:0] ppc,
                       input logic uv, input logic [63:0] upc, input logic ut, input logic up);
        reset = rst;
        pred_req = rq;
        pred_pc = ppc;
        upd_valid = uv;
        upd_pc = upc;
        upd_taken = ut;
        upd_predicted = up;
        @(posedge clk);
        #1;
        model_step();
        check("ready", 64'(ready), 64'(m_ready));
        check("pred_valid", 64'(pred_valid), 64'(m_pv));
        check("pred_taken", 64'(pred_taken), 64'(m_pt));
        check("mispredict_count", 64'(mispredict_count), 64'(m_count));
    endtask

    // Pulse reset, then count cycles (reset cycle included) with ready low.
    task automatic reset_and_wait(input int idle_req, output int lows);
        lows = 0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        if (!ready) lows++;
        while (!ready && lows < 200) begin
            cyc(0, idle_req[0], 64'h100, idle_req[0], 64'h100, 1'b1, 1'b0);
            if (!ready) lows++;
        end
    endtask

    initial begin
        int lows;
        logic [63:0] pa, pb;
        reset = 1'b1;
        pred_req = 0; pred_pc = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_predicted = 0;
        m_init_cycles = 0; m_ready = 0; m_pv = 0; m_pt = 0; m_count = 0; m_ghr = 0;
        for (int i = 0; i < 64; i++) m_ctr[i] = 0;

        // Reset and INIT latency
        reset_and_wait(0, lows);
        check("ready_latency", 64'(lows), 64'd64);
        cyc(0, 1, 64'h100, 0, 0, 0, 0);
        check("first_pred_taken", 64'(pred_taken), 64'd0);

        // Training and saturation
        cyc(0, 0, 0, 1, 64'h100, 1, 0);
        cyc(0, 0, 0, 1, 64'h100, 1, 1);
        cyc(0, 1, 64'h100, 0, 0, 0, 0);
        cyc(0, 1, 64'h200, 0, 0, 0, 0);
        cyc(0, 1, 64'h104, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 64'h100, 0, 1);
        cyc(0, 1, 64'h100, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 64'h100, 1, 64'h100, 0, 0);
        cyc(0, 1, 64'h100, 0, 0, 0, 0);

        // Same-cycle bypass, entry driven back to weak not-taken first
        cyc(0, 0, 0, 1, 64'h108, 0, 0);
        cyc(0, 0, 0, 1, 64'h108, 0, 0);
        cyc(0, 0, 0, 1, 64'h108, 1, 1);
        cyc(0, 1, 64'h108, 1, 64'h108, 1, 1);
        cyc(0, 1, 64'h10C, 1, 64'h110, 1, 0);

        // Mispredict counter clears on reset; INIT-time updates are dropped
        reset_and_wait(1, lows);
        check("ready_latency_upd", 64'(lows), 64'd64);
        check("count_after_init", 64'(mispredict_count), 64'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 64'h140, 1, 0);
        cyc(0, 0, 0, 1, 64'h140, 0, 0);
        check("count_three", 64'(mispredict_count), 64'd3);

        // Reset in the middle of INIT restarts the full sweep
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) cyc(0, 1, 64'h100, 0, 0, 0, 0);
        reset_and_wait(1, lows);
        check("ready_latency_midinit", 64'(lows), 64'd64);
        cyc(0, 0, 0, 1, 64'h100, 1, 1);
        cyc(0, 1, 64'h100, 0, 0, 0, 0);
        cyc(0, 1, 64'h104, 0, 0, 0, 0);

        // Random traffic on a small PC pool to force aliasing and collisions
        for (int n = 0; n < 4000; n++) begin
            pa = (64'($urandom_range(0, 3)) << 40) | (64'($urandom_range(0, 95)) << 2);
            pb = ($urandom_range(0, 3) == 0) ? pa :
                 ((64'($urandom_range(0, 3)) << 40) | (64'($urandom_range(0, 95)) << 2));
            cyc(($urandom_range(0, 499) == 0), $urandom_range(0, 1) == 1, pa,
                $urandom_range(0, 2) != 0, pb, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Bimodal branch-direction predictor; the fetch-side counterpart to the execute-stage branch condition evaluation.
- Fetch asks for a taken/not-taken guess by PC.
- Execute later returns the resolved outcome, and the matching 2-bit saturating counter is trained with it.
- Also counts mispredictions for performance monitoring.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 entries).
- PC_LSB, 2, lowest PC bit used for indexing; index = pc[PC_LSB+INDEX_BITS-1:PC_LSB].
- INIT_STATE, 2'b01, counter value written to every entry during init (weakly not-taken).
- GHR_BITS, 6, global history length; used only when GSHARE_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ready  output  1  table initialised; high only when the FSM is in RUN.
- pred_req  input  1  prediction request this cycle.
- pred_pc  input  64  PC of the branch being fetched.
- pred_valid  output  1  pred_taken is valid this cycle.
- pred_taken  output  1  predicted direction (1 = taken).
- upd_valid  input  1  resolved branch outcome present this cycle.
- upd_pc  input  64  PC of the resolved branch.
- upd_taken  input  1  actual outcome (branch-take decision from execute).
- upd_predicted  input  1  the direction that was predicted for this branch.
- mispredict_count  output  32  saturating count of mispredictions.

Behaviour:
- Clocking: single clock clk; synchronous active-high reset named reset. All state changes on the rising edge of clk.
- Reset values: ready=0, pred_valid=0, pred_taken=0, mispredict_count=0, init pointer=0, FSM=INIT.
- FSM INIT:
  - Writes INIT_STATE to entry[ptr] each cycle, then ptr++.
  - After entry 2^INDEX_BITS-1 is written, goes to RUN.
  - ready rises the cycle after the last write: 2^INDEX_BITS cycles after reset deasserts.
- FSM RUN: ready=1; stays in RUN until reset.
- Reset asserted in any state (including mid-INIT) restarts INIT from ptr=0.
- During INIT:
  - pred_req is ignored; pred_valid stays 0.
  - upd_valid is dropped: no training, no mispredict counting.
- Prediction, latency 1 cycle:
  - pred_req=1 at cycle t (RUN) gives pred_valid=1 at t+1, with pred_taken = entry[idx(pred_pc)][1].
  - No request gives pred_valid=0 and pred_taken=0.
  - Back-to-back requests are accepted every cycle.
- Update, applied at the end of the cycle in which upd_valid=1:
  - upd_taken=1: counter += 1, saturating at 2'b11.
  - upd_taken=0: counter -= 1, saturating at 2'b00.
  - Counter states: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Simultaneous predict and update to the same index in the same cycle: the prediction uses the post-update counter value (write-through bypass). Different indices are independent.
- Aliasing: PCs with identical index bits share an entry; no tag check.
- mispredict_count: +1 on each upd_valid in RUN with upd_taken != upd_predicted; saturates at 32'hFFFF_FFFF.
- The table needs no reset of its storage beyond the INIT sweep; it maps to distributed RAM or flops.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- Defined:
  - Adds a GHR_BITS global history register, reset to 0.
  - On each RUN upd_valid, GHR shifts left and upd_taken enters at bit 0.
  - Both predict and update indices become pc-index XOR GHR, with GHR zero-extended or truncated to INDEX_BITS.
  - Both indices use the GHR value before that edge's shift.
  - The same-index bypass compares hashed indices.
- Undefined: no GHR exists; pure bimodal indexing as above.

Test Plan:
1. Pulse reset for 1 cycle -> ready=0 for 64 cycles, ready=1 from the 65th; then pred_req with pred_pc=0x100 -> next cycle pred_valid=1, pred_taken=0.
2. Training: upd 0x100 taken x2 -> predict 1 (state 11). One not-taken -> predict 1 (state 10). Three not-taken -> predict 0 (state saturated at 00, not wrapped).
3. Aliasing: after training 0x100 taken x2, predict 0x200 (same index 0) -> pred_taken=1; predict 0x104 (index 1) -> pred_taken=0.
4. Bypass: entry at 01, pred_req and upd_valid (taken) for 0x100 in the same cycle -> pred_taken=1 on the next cycle.
5. Counter: 3 updates with upd_predicted!=upd_taken plus 1 matching -> mispredict_count=3; pulse reset -> 0. Updates issued while ready=0 -> count unchanged.
6. Reset mid-INIT: assert reset at init cycle 30 -> ready low for a full 64 cycles after deassert; pred_req during INIT -> pred_valid=0. With GSHARE_EN: one taken update, then predict 0x100 -> reads entry 1.
